// File: rtl/latch_sr_nor.sv
// Gated SR latch vector with NOR cross-coupled output behaviour.
// Level-sensitive storage, transparent while clock is high, with async active-low reset.
`timescale 1ns / 1ps

module latch_sr_nor #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Qa,
    output logic [WIDTH-1:0] Qb,
    output logic [WIDTH-1:0] invalid
);

    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] load;
    logic [WIDTH-1:0] forbidden;

    // The stored value is only rewritten while a request is active.
    // S=R=1 stores 0, which gives the required exits from the forbidden state:
    // dropping S leaves R (stays 0), dropping R leaves S (sets),
    // and dropping both or closing the gate holds 0.
    always_comb begin
        state_d   = S & ~R;
        load      = {WIDTH{clock}} & (S | R);
        forbidden = {WIDTH{reset_n & clock}} & S & R;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic bit_q;

        always_latch begin
            if (!reset_n) begin
                bit_q <= 1'b0;
            end else if (load[i]) begin
                bit_q <= state_d[i];
            end
        end

        assign state_q[i] = bit_q;
    end

    // Both outputs go low together only while the forbidden request is applied.
    always_comb begin
        Qa      = state_q;
        Qb      = ~state_q & ~forbidden;
        invalid = forbidden;
    end

endmodule

// File: tb/tb_latch_sr_nor.sv
// Self-checking bench for latch_sr_nor (WIDTH=1): timed vector table plus
// hand-written reset sequences, with expectations routed through a scoreboard queue.
`timescale 1ns / 1ps

module tb_latch_sr_nor;

    logic       clock;
    logic       reset_n;
    logic [0:0] S;
    logic [0:0] R;
    logic [0:0] Qa;
    logic [0:0] Qb;
    logic [0:0] invalid;

    typedef struct {
        int         t;
        logic       rst_n;
        logic       s;
        logic       r;
        logic [2:0] exp;
    } vec_t;

    typedef struct {
        int         t;
        logic [2:0] exp;
    } sb_t;

    localparam int NVEC = 32;

    vec_t vecs[NVEC];
    sb_t  sb_q[$];
    int   total;
    int   bad;

    latch_sr_nor #(.WIDTH(1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .S       (S),
        .R       (R),
        .Qa      (Qa),
        .Qb      (Qb),
        .invalid (invalid)
    );

    // Clock high 10-20, 30-40, 50-60 ns and so on.
    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    task automatic apply_stimulus(input int t, input logic rst_n, input logic s,
                                  input logic r, input logic [2:0] exp);
        sb_t e;
        if (real'(t) > $realtime) #(real'(t) - $realtime);
        reset_n = rst_n;
        S[0]    = s;
        R[0]    = r;
        e.t     = t;
        e.exp   = exp;
        sb_q.push_back(e);
    endtask

    task automatic check_output();
        sb_t        e;
        logic [2:0] act;
        #0.5;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_empty at %0t: no expectation queued", $time);
        end else begin
            e   = sb_q.pop_front();
            act = {Qa[0], Qb[0], invalid[0]};
            if (act !== e.exp) begin
                bad++;
                $display("[TB] FAIL t%0d {Qa,Qb,invalid}: got %b expected %b", e.t, act, e.exp);
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        S       = 1'b0;
        R       = 1'b0;

        //              t   rst s  r  {Qa,Qb,inv}
        vecs[0]  = '{ 0, 1'b0, 1'b0, 1'b0, 3'b010};
        vecs[1]  = '{ 2, 1'b1, 1'b0, 1'b0, 3'b010};
        vecs[2]  = '{ 8, 1'b1, 1'b1, 1'b0, 3'b010};
        vecs[3]  = '{10, 1'b1, 1'b1, 1'b0, 3'b100};
        vecs[4]  = '{14, 1'b1, 1'b0, 1'b0, 3'b100};
        vecs[5]  = '{20, 1'b1, 1'b0, 1'b0, 3'b100};
        vecs[6]  = '{22, 1'b1, 1'b0, 1'b1, 3'b100};
        vecs[7]  = '{26, 1'b1, 1'b0, 1'b0, 3'b100};
        vecs[8]  = '{27, 1'b1, 1'b0, 1'b1, 3'b100};
        vecs[9]  = '{28, 1'b1, 1'b0, 1'b0, 3'b100};
        vecs[10] = '{29, 1'b1, 1'b0, 1'b1, 3'b100};
        vecs[11] = '{30, 1'b1, 1'b0, 1'b1, 3'b010};
        vecs[12] = '{31, 1'b1, 1'b0, 1'b0, 3'b010};
        vecs[13] = '{33, 1'b1, 1'b1, 1'b0, 3'b100};
        vecs[14] = '{34, 1'b1, 1'b0, 1'b0, 3'b100};
        vecs[15] = '{35, 1'b1, 1'b1, 1'b0, 3'b100};
        vecs[16] = '{36, 1'b1, 1'b0, 1'b0, 3'b100};
        vecs[17] = '{40, 1'b1, 1'b0, 1'b0, 3'b100};
        vecs[18] = '{48, 1'b1, 1'b1, 1'b0, 3'b100};
        vecs[19] = '{50, 1'b1, 1'b1, 1'b0, 3'b100};
        vecs[20] = '{52, 1'b1, 1'b1, 1'b1, 3'b001};
        vecs[21] = '{55, 1'b1, 1'b0, 1'b1, 3'b010};
        vecs[22] = '{58, 1'b1, 1'b0, 1'b0, 3'b010};
        vecs[23] = '{69, 1'b1, 1'b1, 1'b1, 3'b010};
        vecs[24] = '{70, 1'b1, 1'b1, 1'b1, 3'b001};
        vecs[25] = '{72, 1'b1, 1'b1, 1'b0, 3'b100};
        vecs[26] = '{74, 1'b1, 1'b1, 1'b1, 3'b001};
        vecs[27] = '{76, 1'b1, 1'b0, 1'b0, 3'b010};
        vecs[28] = '{77, 1'b1, 1'b1, 1'b0, 3'b100};
        vecs[29] = '{78, 1'b1, 1'b1, 1'b1, 3'b001};
        vecs[30] = '{80, 1'b1, 1'b1, 1'b1, 3'b010};
        vecs[31] = '{82, 1'b1, 1'b0, 1'b0, 3'b010};

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i].t, vecs[i].rst_n, vecs[i].s, vecs[i].r, vecs[i].exp);
            check_output();
        end

        // Reset mid-cycle with clock high and S held, then release with S still high.
        apply_stimulus(88, 1'b1, 1'b1, 1'b0, 3'b010); check_output();
        apply_stimulus(90, 1'b1, 1'b1, 1'b0, 3'b100); check_output();
        apply_stimulus(92, 1'b0, 1'b1, 1'b0, 3'b010); check_output();
        apply_stimulus(94, 1'b1, 1'b1, 1'b0, 3'b100); check_output();
        apply_stimulus(96, 1'b1, 1'b0, 1'b0, 3'b100); check_output();

        // Reset with clock low, and reset overriding the forbidden request.
        apply_stimulus(102, 1'b0, 1'b0, 1'b0, 3'b010); check_output();
        apply_stimulus(104, 1'b1, 1'b0, 1'b0, 3'b010); check_output();
        apply_stimulus(109, 1'b1, 1'b1, 1'b1, 3'b010); check_output();
        apply_stimulus(110, 1'b1, 1'b1, 1'b1, 3'b001); check_output();
        apply_stimulus(112, 1'b0, 1'b1, 1'b1, 3'b010); check_output();
        apply_stimulus(114, 1'b1, 1'b0, 1'b0, 3'b010); check_output();

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
